uart_receiver: RTL and testbench

//  Receive side of the low-speed UART: recovers 8N1/8E1 frames from rx_uart, 16 clk ticks per bit.
//  Bit timing matches uart_controller TX: one clk = one oversample tick.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and the even-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ACTIVE,
    PARITY,
    STOP,
    DONE
  } state_type;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS_DEFAULT  = 8;

  // Zero-extended callers get the same result, so one width serves every DATA_BITS.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side UART signal bundle: line and parity control in, byte and status out.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 parity_en;
  logic                 rx_uart;
  logic                 rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_error;
  logic                 framing_error;
  logic                 busy;

  modport master (
    output parity_en, rx_uart,
    input  rx_data_valid, rx_data, parity_error, framing_error, busy
  );

  modport slave (
    input  parity_en, rx_uart,
    output rx_data_valid, rx_data, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability guard for the asynchronous serial line; flops reset to the idle (high) level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_async,
  output logic rx_s
);
  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_async};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// UART receiver: recovers 8N1/8E1 frames at OVERSAMPLE clk ticks per bit.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 3-tap majority vote per bit, one extra clk of latency.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_receiver_if.slave rx_if
);
  localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int BIT_LAST  = OVERSAMPLE - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int START_LAST = OVERSAMPLE / 2;
`else
  localparam int START_LAST = OVERSAMPLE / 2 - 1;
`endif

  logic                 rx_s;
  logic                 sample;
  state_type            state_reg;
  logic [6:0]           cnt_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 par_en_reg, perr_reg, ferr_reg;
  logic                 valid_reg, parity_error_reg, framing_error_reg, busy_reg;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_async (rx_if.rx_uart),
    .rx_s     (rx_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two previous line values; with the current one they straddle the bit centre.
  logic [1:0] vote_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vote_reg <= '1;
    end else begin
      vote_reg <= {vote_reg[0], rx_s};
    end
  end

  assign sample = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rx_s) | (vote_reg[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      rx_data_reg       <= '0;
      par_en_reg        <= 1'b0;
      perr_reg          <= 1'b0;
      ferr_reg          <= 1'b0;
      valid_reg         <= 1'b0;
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      valid_reg         <= 1'b0;
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) begin
            state_reg   <= START;
            par_en_reg  <= rx_if.parity_en;
            bit_cnt_reg <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == 7'(START_LAST)) begin
            cnt_reg <= '0;
            if (sample) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= ACTIVE;
            end
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        ACTIVE: begin
          if (cnt_reg == 7'(BIT_LAST)) begin
            cnt_reg     <= '0;
            shift_reg   <= {sample, shift_reg[DATA_BITS-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
            if (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
              state_reg <= par_en_reg ? PARITY : STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        PARITY: begin
          if (cnt_reg == 7'(BIT_LAST)) begin
            cnt_reg   <= '0;
            perr_reg  <= sample ^ even_parity(32'(shift_reg));
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        STOP: begin
          if (cnt_reg == 7'(BIT_LAST)) begin
            cnt_reg   <= '0;
            ferr_reg  <= ~sample;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        DONE: begin
          rx_data_reg       <= shift_reg;
          valid_reg         <= 1'b1;
          parity_error_reg  <= perr_reg;
          framing_error_reg <= ferr_reg;
          cnt_reg           <= '0;
          state_reg         <= IDLE;
          busy_reg          <= 1'b0;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data_valid = valid_reg;
  assign rx_if.rx_data       = rx_data_reg;
  assign rx_if.parity_error  = parity_error_reg;
  assign rx_if.framing_error = framing_error_reg;
  assign rx_if.busy          = busy_reg;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, corner sequences, random back-to-back stream.
module tb_uart_receiver;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int SYNC_STAGES = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAT = 1;
`else
  localparam int VOTE_LAT = 0;
`endif
  // Held-low line long enough for two break frames, released before a third start centre.
  localparam int BREAK_LEN = 2 * OS * (DB + 2) - 8;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         flip;
    bit         stop_val;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks_total = 0;
  int   checks_passed = 0;
  int   flag_leak = 0;
  rec_t rcv_q[$];
  rec_t exp_q[$];
  vec_t vecs[9];

  uart_receiver_if #(.DATA_BITS(DB)) rx_if ();

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.rx_data_valid === 1'b1) begin
      rcv_q.push_back('{rx_if.rx_data, rx_if.parity_error, rx_if.framing_error, cyc});
    end else if (rx_if.parity_error !== 1'b0 || rx_if.framing_error !== 1'b0) begin
      flag_leak++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", checks_passed, checks_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Spec latency counted from the clk edge after which the start bit is driven.
  function automatic int frame_lat(input bit pe);
    return SYNC_STAGES + 1 + OS / 2 + OS * (DB + 1 + int'(pe)) + 1 + VOTE_LAT;
  endfunction

  task automatic drive_bit(input logic b);
    rx_if.rx_uart = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pe, input bit flip,
                            input bit stop_val, output int t0);
    rx_if.parity_en = pe;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (pe) drive_bit((^d) ^ flip);
    drive_bit(stop_val);
    rx_if.rx_uart = 1'b1;
  endtask

  task automatic settle(input string tag);
    int   waited = 0;
    rec_t e, r;
    while (rcv_q.size() < exp_q.size() && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    repeat (40) @(posedge clk);
    #1;
    check($sformatf("%s count", tag), rcv_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rcv_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rcv_q.pop_front();
      $display("rx %s: data=%02h perr=%0b ferr=%0b cyc=%0d (want %02h %0b %0b %0d)",
               tag, r.data, r.perr, r.ferr, r.cyc, e.data, e.perr, e.ferr, e.cyc);
      check($sformatf("%s data", tag), r.data, e.data);
      check($sformatf("%s parity_error", tag), r.perr, e.perr);
      check($sformatf("%s framing_error", tag), r.ferr, e.ferr);
      check($sformatf("%s latency", tag), r.cyc, e.cyc);
    end
    exp_q.delete();
    rcv_q.delete();
  endtask

  initial begin
    int         t0, gap;
    bit         pe, flip;
    logic [7:0] d;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
    vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[8] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};

    rx_if.rx_uart   = 1'b1;
    rx_if.parity_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", rx_if.rx_data_valid, 1'b0);
    check("reset rx_data", rx_if.rx_data, 8'h00);
    check("reset parity_error", rx_if.parity_error, 1'b0);
    check("reset framing_error", rx_if.framing_error, 1'b0);
    check("reset busy", rx_if.busy, 1'b0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].flip, vecs[i].stop_val, t0);
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr,
                        t0 + frame_lat(vecs[i].pe)});
      settle($sformatf("vec%0d", i));
      check($sformatf("vec%0d hold", i), rx_if.rx_data, vecs[i].exp_data);
    end

    // Short low glitch on an idle line must be rejected as a false start.
    rx_if.parity_en = 1'b0;
    rx_if.rx_uart = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx_if.rx_uart = 1'b1;
    check("glitch busy seen", rx_if.busy, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch busy cleared", rx_if.busy, 1'b0);
    settle("glitch");

    // Break: two framing-error frames back to back, then normal traffic recovers.
    t0 = cyc;
    rx_if.rx_uart = 1'b0;
    repeat (BREAK_LEN) @(posedge clk);
    #1 rx_if.rx_uart = 1'b1;
    exp_q.push_back('{8'h00, 1'b0, 1'b1, t0 + frame_lat(1'b0)});
    exp_q.push_back('{8'h00, 1'b0, 1'b1, t0 + 2 * frame_lat(1'b0) - SYNC_STAGES});
    settle("break");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, t0);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0, t0 + frame_lat(1'b0)});
    settle("after break");

    // Reset in the middle of data bit 4 of 0xFF aborts the frame silently.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("abort busy before reset", rx_if.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort busy in reset", rx_if.busy, 1'b0);
    check("abort valid in reset", rx_if.rx_data_valid, 1'b0);
    check("abort rx_data in reset", rx_if.rx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    settle("abort");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, t0);
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, t0 + frame_lat(1'b0)});
    settle("after abort");

    // Mostly back-to-back stream of every byte value, random parity mode and occasional bad parity.
    for (int b = 0; b < 256; b++) begin
      d    = 8'(b);
      pe   = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 7) == 0);
      gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send_frame(d, pe, flip, 1'b1, t0);
      exp_q.push_back('{d, pe && (((^d) ^ flip) != (^d)), 1'b0, t0 + frame_lat(pe)});
    end
    settle("stream");

    check("flags outside valid", flag_leak, 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
